// File: rtl/debounce_onepulse.sv
// debounce_onepulse: turns a raw push-button level into a clean debounced level
// plus a one-clock press pulse. When LONG_PRESS_EN is defined it also emits a
// one-clock long_pulse after HOLD_TICKS sample ticks of continuous press.
// Ports:
//   clk          - system clock, all logic on the rising edge
//   rst          - synchronous reset, active-high
//   pb_in        - raw asynchronous button level, 1 = pressed
//   pb_debounced - debounced, registered button level
//   pb_pulse     - one-cycle pulse per debounced press
//   long_pulse   - one-cycle pulse on long press (constant 0 without LONG_PRESS_EN)
// Latency: 2 (sync) + up to DB_DEPTH*SAMPLE_DIV + 2 clocks from stable press to pb_pulse.
// Optional feature macro: LONG_PRESS_EN (hold counter and HELD state).
module debounce_onepulse #(
  parameter int SAMPLE_DIV = 100000,
  parameter int DB_DEPTH   = 4,
  parameter int HOLD_TICKS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pb_debounced,
  output logic pb_pulse,
  output logic long_pulse
);

  localparam int            CW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

  // Two-flop synchronizer; only pb_s is used downstream.
  logic pb_meta;
  logic pb_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      pb_meta <= 1'b0;
      pb_s    <= 1'b0;
    end else begin
      pb_meta <= pb_in;
      pb_s    <= pb_meta;
    end
  end

  // Free-running prescaler; tick marks the last count of each period.
  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sample history; the level only moves once the whole window agrees.
  logic [DB_DEPTH-1:0] sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
    end else if (tick) begin
      sh <= {sh[DB_DEPTH-2:0], pb_s};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pb_debounced <= 1'b0;
    end else if (&sh) begin
      pb_debounced <= 1'b1;
    end else if (~|sh) begin
      pb_debounced <= 1'b0;
    end
  end

  // One-pulse FSM
`ifdef LONG_PRESS_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam int            HW       = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  logic [HW-1:0] hold_cnt;
  logic          long_nxt;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1
  } state_t;
`endif

  state_t state;
  state_t state_nxt;
  logic   pulse_nxt;

  always_comb begin
    state_nxt = IDLE;
    pulse_nxt = 1'b0;
`ifdef LONG_PRESS_EN
    long_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pb_debounced) begin
          state_nxt = PRESSED;
          pulse_nxt = 1'b1;
        end
      end
      PRESSED: begin
        state_nxt = PRESSED;
        if (!pb_debounced) begin
          state_nxt = IDLE;
`ifdef LONG_PRESS_EN
        end else if (hold_cnt == HOLD_MAX) begin
          state_nxt = HELD;
          long_nxt  = 1'b1;
`endif
        end
      end
`ifdef LONG_PRESS_EN
      HELD: begin
        state_nxt = pb_debounced ? HELD : IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pb_pulse <= 1'b0;
    end else begin
      state    <= state_nxt;
      pb_pulse <= pulse_nxt;
    end
  end

`ifdef LONG_PRESS_EN
  // Counts ticks of continuous press; saturates so a very long hold never
  // re-triggers, and is cleared whenever the FSM sits in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (state == PRESSED && tick && hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= long_nxt;
    end
  end
`else
  // HOLD_TICKS only matters with long-press support; it is still referenced
  // so both builds expose the same parameter list without dead-code noise.
  logic unused_hold_cfg;
  assign unused_hold_cfg = (HOLD_TICKS > 0);
  assign long_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_onepulse.sv
module tb_debounce_onepulse;

  localparam int SAMPLE_DIV = 4;
  localparam int DB_DEPTH   = 4;
  localparam int HOLD_TICKS = 8;

  logic clk;
  logic rst;
  logic pb_in;
  logic pb_debounced;
  logic pb_pulse;
  logic long_pulse;

  debounce_onepulse #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .DB_DEPTH   (DB_DEPTH),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pb_in        (pb_in),
    .pb_debounced (pb_debounced),
    .pb_pulse     (pb_pulse),
    .long_pulse   (long_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int long_cnt  = 0;

  // Reference model: edge index since reset, two-cycle input history, and the
  // debouncer described as "current run of identical samples".
  int   m_n;
  logic h0, h1;
  logic run_val;
  int   run_len;
  logic m_deb, m_deb_d, m_pulse;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic s;
    if (rst) begin
      m_n = 0; h0 = 1'b0; h1 = 1'b0;
      run_val = 1'b0; run_len = DB_DEPTH;
      m_deb = 1'b0; m_deb_d = 1'b0; m_pulse = 1'b0;
    end else begin
      m_n++;
      // pulse follows a rise of the debounced level by one cycle
      m_pulse = m_deb && !m_deb_d;
      m_deb_d = m_deb;
      if (run_len >= DB_DEPTH) m_deb = run_val;
      // a sample is taken every SAMPLE_DIV-th edge, of the input 2 edges old
      if (m_n % SAMPLE_DIV == 0) begin
        s = h1;
        if (s == run_val) begin
          if (run_len < DB_DEPTH) run_len++;
        end else begin
          run_val = s;
          run_len = 1;
        end
      end
      h1 = h0;
      h0 = pb_in;
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs checked
  // on the falling edge, inputs then changed by the caller.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("deb_vs_model", int'(pb_debounced), int'(m_deb));
    chk("pulse_vs_model", int'(pb_pulse), int'(m_pulse));
`ifndef LONG_PRESS_EN
    chk("long_tied_low", int'(long_pulse), 0);
`endif
    pulse_cnt += int'(pb_pulse);
    long_cnt  += int'(long_pulse);
  endtask

  typedef struct {
    logic pb;
    int   cycles;
    logic exp_deb;
    int   exp_pulses;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int lat;
    int t_p;
    int t_l;
    int len;

    tbl[0] = '{1'b0, 12, 1'b0, 0};
    tbl[1] = '{1'b1, 40, 1'b1, 1};   // first press
    tbl[2] = '{1'b0, 40, 1'b0, 0};   // release: no pulse
    tbl[3] = '{1'b1, 40, 1'b1, 1};   // second press
    tbl[4] = '{1'b0, 40, 1'b0, 0};
    tbl[5] = '{1'b1,  6, 1'b0, 0};   // bursts shorter than the sample window
    tbl[6] = '{1'b0,  6, 1'b0, 0};
    tbl[7] = '{1'b1,  6, 1'b0, 0};
    tbl[8] = '{1'b0,  6, 1'b0, 0};
    tbl[9] = '{1'b0, 40, 1'b0, 0};

    // Reset with unknown input
    rst   = 1'b1;
    pb_in = 1'bx;
    cyc();
    cyc();
    chk("reset_deb", int'(pb_debounced), 0);
    chk("reset_pulse", int'(pb_pulse), 0);
    chk("reset_long", int'(long_pulse), 0);

    // Prescaler: tick in the last cycle of every SAMPLE_DIV-cycle period
    rst   = 1'b0;
    pb_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("tick_cycle%0d", k), int'(dut.tick), int'(k % SAMPLE_DIV == SAMPLE_DIV - 1));
    end

    // Press latency and pulse width
    pb_in = 1'b1;
    lat   = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (pb_debounced) begin
        lat = k;
        break;
      end
    end
    chk("deb_latency_min", int'(lat >= (DB_DEPTH - 1) * SAMPLE_DIV + 3), 1);
    chk("deb_latency_max", int'(lat >= 1 && lat <= 2 + DB_DEPTH * SAMPLE_DIV + 2), 1);
    cyc();
    chk("pulse_one_after_deb", int'(pb_pulse), 1);
    cyc();
    chk("pulse_width_one", int'(pb_pulse), 0);
    pulse_cnt = 0;
    repeat (40) cyc();
    chk("no_repulse_while_held", pulse_cnt, 0);
    pb_in = 1'b0;
    repeat (40) cyc();

    // Table-driven segments
    for (int i = 0; i < 10; i++) begin
      pb_in     = tbl[i].pb;
      pulse_cnt = 0;
      repeat (tbl[i].cycles) cyc();
      chk($sformatf("row%0d_deb", i), int'(pb_debounced), int'(tbl[i].exp_deb));
      chk($sformatf("row%0d_pulses", i), pulse_cnt, tbl[i].exp_pulses);
    end

    // Reset while pressed, input held high
    pb_in = 1'b1;
    repeat (40) cyc();
    chk("pre_reset_deb", int'(pb_debounced), 1);
    rst = 1'b1;
    cyc();
    chk("midpress_reset_deb", int'(pb_debounced), 0);
    chk("midpress_reset_pulse", int'(pb_pulse), 0);
    chk("midpress_reset_long", int'(long_pulse), 0);
    rst       = 1'b0;
    pulse_cnt = 0;
    repeat (40) cyc();
    chk("after_reset_pulses", pulse_cnt, 1);
    chk("after_reset_deb", int'(pb_debounced), 1);
    pb_in = 1'b0;
    repeat (40) cyc();

`ifdef LONG_PRESS_EN
    // Long hold: one press pulse, then one long pulse about HOLD_TICKS ticks later
    pb_in = 1'b1;
    pulse_cnt = 0; long_cnt = 0; t_p = -1; t_l = -1;
    for (int k = 1; k <= 80; k++) begin
      cyc();
      if (pb_pulse && t_p < 0) t_p = k;
      if (long_pulse && t_l < 0) t_l = k;
    end
    pb_in = 1'b0;
    repeat (40) cyc();
    chk("long_hold_pulses", pulse_cnt, 1);
    chk("long_hold_long_pulses", long_cnt, 1);
    chk("long_gap_in_range", int'(t_p > 0 && t_l - t_p >= 29 && t_l - t_p <= 34), 1);

    // Short hold: release before the long threshold
    pb_in = 1'b1;
    pulse_cnt = 0; long_cnt = 0;
    repeat (20) cyc();
    pb_in = 1'b0;
    repeat (40) cyc();
    chk("short_hold_pulses", pulse_cnt, 1);
    chk("short_hold_long_pulses", long_cnt, 0);
`else
    t_p = 0; t_l = 0;
`endif

    // Bounce: 6 high / 2 low bursts, then settle low
    for (int b = 0; b < 5; b++) begin
      pb_in = 1'b1;
      repeat (6) cyc();
      pb_in = 1'b0;
      repeat (2) cyc();
    end
    repeat (40) cyc();

    // Randomised levels and run lengths against the model
    for (int s = 0; s < 200; s++) begin
      pb_in = 1'($urandom_range(0, 1));
      len   = int'($urandom_range(1, 30));
      repeat (len) cyc();
    end
    pb_in = 1'b0;
    repeat (40) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
